// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy is held for a fixed latency per operation.
// Optional feature macro: MDU_MADD_EN adds madd/maddu/msub/msubu accumulate operations.
module mdu_multicycle #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] result
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_MULT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] CNT_DIV  = CW'(DIV_CYCLES);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   hi_n_q, hi_n_d, lo_n_q, lo_n_d;
    logic          wr_q, wr_d;

    logic [63:0]   prod_signed, prod_unsigned;
    logic          div_signed;
    logic [31:0]   dividend_mag, divisor_mag, quot_mag, rem_mag, quot, rem;
    logic          launch_ok;
    logic [CW-1:0] launch_cnt;
    logic [63:0]   launch_res;
    logic          launch_wr;

    // Products and a single magnitude divider shared by div and divu.
    always_comb begin
        prod_signed   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_unsigned = {32'd0, A} * {32'd0, B};
        div_signed    = (MDUOp == OP_DIV);
        dividend_mag  = (div_signed && A[31]) ? (32'd0 - A) : A;
        divisor_mag   = (div_signed && B[31]) ? (32'd0 - B) : B;
        if (divisor_mag == 32'd0) begin
            quot_mag = 32'd0;
            rem_mag  = 32'd0;
        end else begin
            quot_mag = dividend_mag / divisor_mag;
            rem_mag  = dividend_mag % divisor_mag;
        end
        // Quotient truncates toward zero; remainder carries the dividend's sign.
        quot = (div_signed && (A[31] ^ B[31])) ? (32'd0 - quot_mag) : quot_mag;
        rem  = (div_signed && A[31]) ? (32'd0 - rem_mag) : rem_mag;
    end

    // Decode of launchable operations and the result they will commit.
    always_comb begin
        launch_ok  = 1'b0;
        launch_cnt = CNT_ZERO;
        launch_res = {hi_q, lo_q};
        launch_wr  = 1'b0;
        case (MDUOp)
            OP_MULT:  begin launch_ok = 1'b1; launch_cnt = CNT_MULT; launch_res = prod_signed;   launch_wr = 1'b1; end
            OP_MULTU: begin launch_ok = 1'b1; launch_cnt = CNT_MULT; launch_res = prod_unsigned; launch_wr = 1'b1; end
            OP_DIV, OP_DIVU: begin
                launch_ok  = 1'b1;
                launch_cnt = CNT_DIV;
                launch_res = {rem, quot};
                launch_wr  = (B != 32'd0);
            end
`ifdef MDU_MADD_EN
            OP_MADD:  begin launch_ok = 1'b1; launch_cnt = CNT_MULT; launch_res = {hi_q, lo_q} + prod_signed;   launch_wr = 1'b1; end
            OP_MADDU: begin launch_ok = 1'b1; launch_cnt = CNT_MULT; launch_res = {hi_q, lo_q} + prod_unsigned; launch_wr = 1'b1; end
            OP_MSUB:  begin launch_ok = 1'b1; launch_cnt = CNT_MULT; launch_res = {hi_q, lo_q} - prod_signed;   launch_wr = 1'b1; end
            OP_MSUBU: begin launch_ok = 1'b1; launch_cnt = CNT_MULT; launch_res = {hi_q, lo_q} - prod_unsigned; launch_wr = 1'b1; end
`endif
            default: begin
                launch_ok = 1'b0;
            end
        endcase
    end

    // Next-state logic: launch from IDLE, count down in RUN, commit on the last cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_n_d  = hi_n_q;
        lo_n_d  = lo_n_q;
        wr_d    = wr_q;
        case (state_q)
            S_IDLE: begin
                if (start && launch_ok) begin
                    state_d          = S_RUN;
                    cnt_d            = launch_cnt;
                    {hi_n_d, lo_n_d} = launch_res;
                    wr_d             = launch_wr;
                end else begin
                    state_d = S_IDLE;
                end
                if (MDUOp == OP_MTHI) begin
                    hi_d = A;
                end else if (MDUOp == OP_MTLO) begin
                    lo_d = A;
                end else begin
                    hi_d = hi_q;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                    if (wr_q) begin
                        hi_d = hi_n_q;
                        lo_d = lo_n_q;
                    end else begin
                        hi_d = hi_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hi_n_q  <= 32'd0;
            lo_n_q  <= 32'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_n_q  <= hi_n_d;
            lo_n_q  <= lo_n_d;
            wr_q    <= wr_d;
        end
    end

    // mfhi/mflo read port; stale while busy by design.
    always_comb begin
        case (MDUOp)
            OP_MFHI: result = hi_q;
            OP_MFLO: result = lo_q;
            default: result = 32'd0;
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: tb/tb_mdu_multicycle.sv
// Self-checking bench for mdu_multicycle: directed plan cases plus randomized ops vs. an arithmetic model.
module tb_mdu_multicycle;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  MDUOp;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO, result;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_hi, m_lo;

    mdu_multicycle dut (
        .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp), .A(A), .B(B),
        .busy(busy), .HI(HI), .LO(LO), .result(result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: latency, committed {HI,LO} and whether a write happens, from plain arithmetic.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output int n, output logic [63:0] res, output logic wr);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        sp  = longint'($signed(a)) * longint'($signed(b));
        up  = {32'd0, a} * {32'd0, b};
        sa  = $signed(a);
        sb  = $signed(b);
        n   = 0;
        res = {m_hi, m_lo};
        wr  = 1'b0;
        case (op)
            4'd1: begin n = MC; res = sp; wr = 1'b1; end
            4'd2: begin n = MC; res = up; wr = 1'b1; end
            4'd3: begin
                n = DC;
                if (b == 32'd0) wr = 1'b0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin res = {32'd0, a}; wr = 1'b1; end
                else begin res = {32'(sa % sb), 32'(sa / sb)}; wr = 1'b1; end
            end
            4'd4: begin
                n = DC;
                if (b != 32'd0) begin res = {a % b, a / b}; wr = 1'b1; end
            end
`ifdef MDU_MADD_EN
            4'd9:  begin n = MC; res = {m_hi, m_lo} + 64'(sp); wr = 1'b1; end
            4'd10: begin n = MC; res = {m_hi, m_lo} + up;      wr = 1'b1; end
            4'd11: begin n = MC; res = {m_hi, m_lo} - 64'(sp); wr = 1'b1; end
            4'd12: begin n = MC; res = {m_hi, m_lo} - up;      wr = 1'b1; end
`endif
            default: n = 0;
        endcase
    endfunction

    // Launch op with start, scramble operands during RUN, check busy window and committed HI/LO.
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          n;
        logic [63:0] res;
        logic        wr;
        model(op, a, b, n, res, wr);
        start = 1'b1; MDUOp = op; A = a; B = b;
        tick();
        start = 1'b0; MDUOp = 4'd0; A = $urandom; B = $urandom;
        for (int i = 0; i < n; i++) begin
            check("busy_run", {31'd0, busy}, 32'd1);
            check("hi_stale", HI, m_hi);
            tick();
        end
        if (wr) {m_hi, m_lo} = res;
        check("busy_done", {31'd0, busy}, 32'd0);
        check("hi_commit", HI, m_hi);
        check("lo_commit", LO, m_lo);
    endtask

    task automatic move(input logic [3:0] op, input logic [31:0] a);
        MDUOp = op; A = a; start = 1'b0;
        tick();
        if (op == 4'd5) m_hi = a;
        else if (op == 4'd6) m_lo = a;
        MDUOp = 4'd0;
        check("mt_busy", {31'd0, busy}, 32'd0);
        check("mt_hi", HI, m_hi);
        check("mt_lo", LO, m_lo);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        tick();
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        MDUOp = 4'd7; #1;
        check("rst_result", result, 32'd0);
        MDUOp = 4'd0;

        launch(4'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFE);
        launch(4'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        check("multu_hi", HI, 32'h0000_0001);
        check("multu_lo", LO, 32'hFFFF_FFFE);
        launch(4'd3, 32'hFFFF_FFF9, 32'd2);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);
        launch(4'd4, 32'd7, 32'd2);
        check("divu_lo", LO, 32'd3);
        check("divu_hi", HI, 32'd1);
        launch(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);

        move(4'd5, 32'h1234_5678);
        check("mthi_hi", HI, 32'h1234_5678);
        MDUOp = 4'd7; #1;
        check("mfhi", result, 32'h1234_5678);
        MDUOp = 4'd8; #1;
        check("mflo", result, m_lo);
        MDUOp = 4'd0;
        launch(4'd3, 32'h0000_0064, 32'd0);
        check("div0_hi", HI, 32'h1234_5678);

        // mult in flight: div pulse on busy cycle 2 and mtlo on cycle 3 must be ignored.
        begin
            int          n;
            logic [63:0] res;
            logic        wr;
            model(4'd1, 32'h0001_0003, 32'hFFFF_FFFE, n, res, wr);
            start = 1'b1; MDUOp = 4'd1; A = 32'h0001_0003; B = 32'hFFFF_FFFE;
            tick();
            start = 1'b0; MDUOp = 4'd0;
            for (int i = 1; i <= MC; i++) begin
                check("ign_busy", {31'd0, busy}, 32'd1);
                start = (i == 2); MDUOp = (i == 2) ? 4'd3 : ((i == 3) ? 4'd6 : 4'd0);
                A = 32'h0000_0009; B = 32'd3;
                tick();
            end
            start = 1'b0; MDUOp = 4'd0;
            {m_hi, m_lo} = res;
            check("ign_done", {31'd0, busy}, 32'd0);
            check("ign_hi", HI, m_hi);
            check("ign_lo", LO, m_lo);
            tick();
            check("ign_no_restart", {31'd0, busy}, 32'd0);
        end

        // Reset on the 4th busy cycle of divu aborts it.
        start = 1'b1; MDUOp = 4'd4; A = 32'd100; B = 32'd7;
        tick();
        start = 1'b0; MDUOp = 4'd0;
        for (int i = 1; i < 4; i++) tick();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        for (int i = 0; i < DC; i++) tick();
        check("abort_late_hi", HI, 32'd0);
        check("abort_late_lo", LO, 32'd0);

        move(4'd5, 32'd0);
        move(4'd6, 32'hFFFF_FFFF);
        launch(4'd9, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        check("madd_hi", HI, 32'h0000_0001);
        check("madd_lo", LO, 32'h0000_0000);
`else
        check("madd_off_hi", HI, 32'h0000_0000);
        check("madd_off_lo", LO, 32'hFFFF_FFFF);
`endif

        for (int k = 0; k < 60; k++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            if (op == 4'd5 || op == 4'd6) begin
                move(op, a);
            end else if (op == 4'd7 || op == 4'd8) begin
                MDUOp = op; #1;
                check("rnd_mf", result, (op == 4'd7) ? m_hi : m_lo);
                MDUOp = 4'd0;
            end else begin
                launch(op, a, b);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
